scytale_codec: RTL and testbench
================================

SCYTALE_CODEC -- requirements
Module: scytale_codec

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8, meaning character width in bits.
REQ-002 SHALL have parameter KEY_WIDTH, default 8, meaning width of each key operand.
REQ-003 SHALL have parameter MAX_NOF_CHARS, default 50, meaning buffer depth in characters.
REQ-004 SHALL have parameter START_TOKEN, default 8'hFA, meaning the character that ends collection and starts processing.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port data_i, input, D_WIDTH bits: input character.
REQ-008 SHALL have port valid_i, input, 1 bit: data_i is valid this cycle.
REQ-009 SHALL have port key_N, input, KEY_WIDTH bits: scytale column count.
REQ-010 SHALL have port key_M, input, KEY_WIDTH bits: scytale row count.
REQ-011 SHALL have port mode_i, input, 1 bit: 0 selects decrypt, 1 selects encrypt.
REQ-012 SHALL have port data_o, output, D_WIDTH bits: output character, registered.
REQ-013 SHALL have port valid_o, output, 1 bit: data_o is valid, registered.
REQ-014 SHALL have port busy, output, 1 bit: the block is emitting and ignores input, registered.
REQ-015 SHALL have port err_o, output, 1 bit: one-cycle pulse when a token is rejected.
REQ-016 SHALL have port ovf_o, output, 1 bit: sticky flag set when characters were dropped because the buffer was full.

Function
REQ-017 SHALL implement two states, COLLECT (after reset) and EMIT, with busy=1 exactly while in EMIT.
REQ-018 In COLLECT, valid_i=1 with data_i!=START_TOKEN and count<MAX_NOF_CHARS SHALL store data_i at index count and increment count.
REQ-019 In COLLECT, a non-token valid character with count==MAX_NOF_CHARS SHALL be dropped and SHALL set ovf_o; the buffer is left unchanged.
REQ-020 In COLLECT, valid_i=1 with data_i==START_TOKEN SHALL latch key_N, key_M and mode_i and compute L=key_N*key_M at 2*KEY_WIDTH bits with no truncation.
REQ-021 The token SHALL be rejected when L==0, L!=count, or L>MAX_NOF_CHARS.
REQ-022 On a rejected token: err_o=1 for the next cycle only, count cleared to 0, ovf_o cleared, and the block stays in COLLECT.
REQ-023 An accepted token at edge E SHALL give busy=1 after E and enter EMIT; ovf_o is cleared at E.
REQ-024 In EMIT, one character per cycle SHALL be presented on data_o with valid_o=1, at edges E+1 through E+L.
REQ-025 Decrypt order SHALL be index j+t*N, with outer loop j=0..N-1 and inner loop t=0..M-1.
REQ-026 Encrypt order SHALL be index j+t*M, with outer loop j=0..M-1 and inner loop t=0..N-1; this order is the exact inverse of decrypt.
REQ-027 Indices SHALL be generated by stride/column counters (add and compare only); no multiplier sits in the index path.
REQ-028 At edge E+L+1 the block SHALL set valid_o=0, data_o=0 and busy=0, clear count, and return to COLLECT.
REQ-029 While busy=1, valid_i SHALL be ignored, including START_TOKEN characters; no characters are stored.
REQ-030 key_N, key_M and mode_i changes during EMIT SHALL NOT affect the current message.
REQ-031 A valid character arriving on the cycle busy falls SHALL be accepted as the first character of the next message.
REQ-032 When valid_o=0, data_o SHALL be 0.

Reset
REQ-033 rst=1 SHALL, at the next edge, force data_o=0, valid_o=0, busy=0, err_o=0, ovf_o=0, count=0 and state COLLECT, including mid-EMIT with the message discarded.
REQ-034 Buffer contents SHALL NOT require reset; they are unobservable until rewritten.

Verification
REQ-035 Decrypt: N=2, M=3, mode=0, send "ABCDEF" then 0xFA -> data_o "ACEBDF" on 6 consecutive cycles, then busy=0 one cycle later.
REQ-036 Encrypt: N=2, M=3, mode=1, send "ACEBDF" then 0xFA -> "ABCDEF"; round trip through both modes is identity.
REQ-037 Mismatch: N=2, M=3, send 5 characters then 0xFA -> err_o high one cycle, valid_o stays 0, next valid message of 6 processes correctly.
REQ-038 Overflow: MAX_NOF_CHARS=50, send 52 characters, N=5, M=10, then 0xFA -> ovf_o=1 before the token, first 50 emitted in scytale order, ovf_o=0 after the token.
REQ-039 Busy/reset: during EMIT drive 0xFA and 'X' plus key changes -> output unaffected; then assert rst mid-EMIT -> all outputs 0 next cycle, fresh message works.

Source files
------------

// File: rtl/scytale_codec.sv
// Scytale transposition codec: collects characters until START_TOKEN, then
// streams them back in scytale order (decrypt or encrypt) one per cycle.
module scytale_codec #(
  parameter int unsigned         D_WIDTH       = 8,
  parameter int unsigned         KEY_WIDTH     = 8,
  parameter int unsigned         MAX_NOF_CHARS = 50,
  parameter logic [D_WIDTH-1:0]  START_TOKEN   = 8'hFA
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key_N,
  input  logic [KEY_WIDTH-1:0] key_M,
  input  logic                 mode_i,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o,
  output logic                 busy,
  output logic                 err_o,
  output logic                 ovf_o
);

  localparam int unsigned CW = $clog2(MAX_NOF_CHARS + 1);
  localparam int unsigned AW = (MAX_NOF_CHARS > 1) ? $clog2(MAX_NOF_CHARS) : 1;
  localparam int unsigned LW = 2 * KEY_WIDTH;

  typedef enum logic {StCollect, StEmit} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [D_WIDTH-1:0]     data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;
  logic                   ovf_q, ovf_d;
  // Per-message traversal parameters, frozen at the token.
  logic [KEY_WIDTH-1:0]   stride_q, stride_d;
  logic [KEY_WIDTH-1:0]   inner_q, inner_d;
  logic [CW-1:0]          len_q, len_d;
  // Traversal state: characters emitted, inner position, column base, index.
  logic [CW-1:0]          emit_q, emit_d;
  logic [KEY_WIDTH-1:0]   t_q, t_d;
  logic [AW-1:0]          col_q, col_d;
  logic [AW-1:0]          idx_q, idx_d;

  logic [D_WIDTH-1:0]     buf_q [MAX_NOF_CHARS];
  logic                   wr_en;
  logic [LW-1:0]          prod;

  // Message length only; the index path uses add/compare counters.
  assign prod = LW'(key_N) * LW'(key_M);

  // Next-state: collection, token checking and scytale-order traversal.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    data_d   = '0;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    err_d    = 1'b0;
    ovf_d    = ovf_q;
    stride_d = stride_q;
    inner_d  = inner_q;
    len_d    = len_q;
    emit_d   = emit_q;
    t_d      = t_q;
    col_d    = col_q;
    idx_d    = idx_q;
    wr_en    = 1'b0;

    unique case (state_q)
      StCollect: begin
        if (valid_i) begin
          if (data_i == START_TOKEN) begin
            if ((prod == '0) || (prod != LW'(count_q)) ||
                (prod > LW'(MAX_NOF_CHARS))) begin
              err_d   = 1'b1;
              count_d = '0;
              ovf_d   = 1'b0;
            end else begin
              state_d  = StEmit;
              busy_d   = 1'b1;
              ovf_d    = 1'b0;
              // Decrypt walks stride N over M rows; encrypt swaps the roles.
              stride_d = mode_i ? key_M : key_N;
              inner_d  = mode_i ? key_N : key_M;
              len_d    = count_q;
              emit_d   = '0;
              t_d      = '0;
              col_d    = '0;
              idx_d    = '0;
            end
          end else if (count_q < CW'(MAX_NOF_CHARS)) begin
            wr_en   = 1'b1;
            count_d = count_q + CW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      StEmit: begin
        if (emit_q != len_q) begin
          valid_d = 1'b1;
          data_d  = buf_q[idx_q];
          emit_d  = emit_q + CW'(1);
          if (t_q == inner_q - KEY_WIDTH'(1)) begin
            t_d   = '0;
            col_d = col_q + AW'(1);
            idx_d = col_q + AW'(1);
          end else begin
            t_d   = t_q + KEY_WIDTH'(1);
            // Modular add is exact: the true index is always below MAX_NOF_CHARS.
            idx_d = idx_q + AW'(stride_q);
          end
        end else begin
          state_d = StCollect;
          busy_d  = 1'b0;
          count_d = '0;
        end
      end
      default: state_d = StCollect;
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StCollect;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      stride_q <= '0;
      inner_q  <= '0;
      len_q    <= '0;
      emit_q   <= '0;
      t_q      <= '0;
      col_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      stride_q <= stride_d;
      inner_q  <= inner_d;
      len_q    <= len_d;
      emit_q   <= emit_d;
      t_q      <= t_d;
      col_q    <= col_d;
      idx_q    <= idx_d;
    end
  end

  // Character buffer; contents are only read after being rewritten.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_q[count_q[AW-1:0]] <= data_i;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign busy    = busy_q;
  assign err_o   = err_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_scytale_codec.sv
// Scoreboard bench for scytale_codec: stimulus pushes expected characters,
// a negedge monitor pops and compares whenever valid_o is high.
module tb_scytale_codec;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_i;
  logic       valid_i;
  logic [7:0] key_N;
  logic [7:0] key_M;
  logic       mode_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       busy;
  logic       err_o;
  logic       ovf_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  scytale_codec dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .valid_i (valid_i),
    .key_N   (key_N),
    .key_M   (key_M),
    .mode_i  (mode_i),
    .data_o  (data_o),
    .valid_o (valid_o),
    .busy    (busy),
    .err_o   (err_o),
    .ovf_o   (ovf_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c);
    valid_i = 1'b1;
    data_i  = c;
    tick();
    valid_i = 1'b0;
    data_i  = '0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // Called just after the token edge E: L output cycles, then idle at E+L+1.
  task automatic run_emit(input int len);
    check("busy_after_token", busy, 1);
    for (int i = 0; i < len; i++) begin
      tick();
      check("emit_valid", valid_o, 1);
      check("emit_busy", busy, 1);
    end
    tick();
    check("end_busy", busy, 0);
    check("end_valid", valid_o, 0);
    check("end_data", data_o, 0);
  endtask

  // Monitor: scoreboard pop on valid, zero-data check otherwise.
  always @(negedge clk) begin
    if (valid_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {24'h0, data_o}, 32'hFFFF_FFFF);
      end else begin
        check("data_o", data_o, exp_q.pop_front());
      end
    end else begin
      check("idle_data_zero", data_o, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; valid_i = 1'b0; data_i = '0;
    key_N = '0; key_M = '0; mode_i = 1'b0;
    tick();
    tick();
    check("rst_data", data_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_o, 0);
    check("rst_ovf", ovf_o, 0);
    rst = 1'b0;

    // L == 0 token is rejected even with an empty buffer.
    key_N = 8'd0; key_M = 8'd3;
    send(8'hFA);
    check("zero_len_err", err_o, 1);
    check("zero_len_busy", busy, 0);
    tick();
    check("zero_len_err_pulse", err_o, 0);

    // Decrypt N=2 M=3.
    key_N = 8'd2; key_M = 8'd3; mode_i = 1'b0;
    send_str("ABCDEF");
    push_str("ACEBDF");
    send(8'hFA);
    run_emit(6);

    // Encrypt inverts it.
    mode_i = 1'b1;
    send_str("ACEBDF");
    push_str("ABCDEF");
    send(8'hFA);
    run_emit(6);

    // Length mismatch, then a good message.
    mode_i = 1'b0;
    send_str("ABCDE");
    send(8'hFA);
    check("mismatch_err", err_o, 1);
    check("mismatch_busy", busy, 0);
    check("mismatch_valid", valid_o, 0);
    tick();
    check("mismatch_err_pulse", err_o, 0);
    check("mismatch_valid2", valid_o, 0);
    send_str("UVWXYZ");
    push_str("UWYVXZ");
    send(8'hFA);
    run_emit(6);

    // Overflow: 52 characters into a 50-deep buffer.
    key_N = 8'd5; key_M = 8'd10;
    for (int i = 0; i < 52; i++) begin
      send(8'(8'h10 + i));
      if (i == 49) check("ovf_at_full", ovf_o, 0);
      if (i == 50) check("ovf_on_drop", ovf_o, 1);
    end
    check("ovf_before_token", ovf_o, 1);
    for (int j = 0; j < 5; j++)
      for (int t = 0; t < 10; t++) exp_q.push_back(8'(8'h10 + j + t * 5));
    send(8'hFA);
    check("ovf_after_token", ovf_o, 0);
    run_emit(50);

    // Inputs and key changes during EMIT must be ignored.
    key_N = 8'd2; key_M = 8'd3; mode_i = 1'b0;
    send_str("ABCDEF");
    push_str("ACEBDF");
    send(8'hFA);
    check("ign_busy", busy, 1);
    for (int i = 0; i < 6; i++) begin
      valid_i = 1'b1;
      data_i  = (i % 2 == 1) ? 8'h58 : 8'hFA;
      key_N = 8'd7; key_M = 8'd1; mode_i = 1'b1;
      tick();
      check("ign_valid", valid_o, 1);
    end
    valid_i = 1'b0; data_i = '0;
    tick();
    check("ign_end_busy", busy, 0);
    check("ign_end_err", err_o, 0);
    // Sent on the cycle busy falls: must start a fresh, empty message.
    key_N = 8'd3; key_M = 8'd2; mode_i = 1'b0;
    send_str("MNOPQR");
    push_str("MPNQOR");
    send(8'hFA);
    run_emit(6);

    // Reset mid-EMIT discards the rest of the message.
    send_str("GHIJKL");
    push_str("GJ");
    send(8'hFA);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_data", data_o, 0);
    check("mid_rst_valid", valid_o, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", err_o, 0);
    check("mid_rst_ovf", ovf_o, 0);
    rst = 1'b0;
    key_N = 8'd2; key_M = 8'd3; mode_i = 1'b1;
    send_str("ABCDEF");
    push_str("ADBECF");
    send(8'hFA);
    run_emit(6);

    tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
